// File: rtl/rdoq_pkg.sv
// Shared RDOQ constants and types.
// Used by the last-position optimizer and by last_position_applier.
//  - coefficient buffer geometry: up to 32x32 coefficients, 16 per coefficient group
//  - coeff_t: signed coefficient word
//  - applier_state_t: FSM states of last_position_applier
package rdoq_pkg;
   localparam int MAX_COEFF_COUNT = 1024;
   localparam int ADDR_WIDTH      = 10;
   localparam int CG_SIZE         = 16;
   localparam int CG_SHIFT        = 4;   // log2(CG_SIZE)
   localparam int COEFF_WIDTH     = 16;
   localparam int SUM_WIDTH       = COEFF_WIDTH + ADDR_WIDTH;
   localparam int CG_COUNT        = MAX_COEFF_COUNT / CG_SIZE;

   typedef logic signed [COEFF_WIDTH-1:0] coeff_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_RD,
      ST_EVAL,
      ST_DONE
   } applier_state_t;
endpackage

// File: rtl/last_pos_xy_decode.sv
// Raster block position -> (x, y) for a square TU of width 2^log2_width.
// Ports:
//  blk_pos     in   raster position inside the TU
//  log2_width  in   TU width log2 (2..5)
//  pos_x       out  blk_pos & (width-1)
//  pos_y       out  blk_pos >> log2_width
module last_pos_xy_decode
   import rdoq_pkg::*;
(
   input  logic [ADDR_WIDTH-1:0] blk_pos,
   input  logic [2:0]            log2_width,
   output logic [4:0]            pos_x,
   output logic [4:0]            pos_y
);

   logic [ADDR_WIDTH-1:0] col_mask;
   logic [ADDR_WIDTH-1:0] col;
   logic [ADDR_WIDTH-1:0] row;

   always_comb begin
      col_mask = ~({ADDR_WIDTH{1'b1}} << log2_width);
      col      = blk_pos & col_mask;
      row      = blk_pos >> log2_width;
      pos_x    = col[4:0];
      pos_y    = row[4:0];
   end

endmodule

// File: rtl/last_position_applier.sv
// Applies the RDOQ last-position decision to the coefficient buffer.
// Walks scan positions iLastScanPos..0 (RD fetches, EVAL consumes), zeroes
// every nonzero coefficient at scan position >= best, and rebuilds the
// group significance flags, the absolute level sum and the last (x,y).
// Ports:
//  clk, rst                     clock, asynchronous active-high reset
//  start / done                 pass handshake; done held until start drops
//  iBestLastIdxP1               chosen last index + 1 (0 = all-zero block)
//  iLastScanPos                 pre-RDOQ last scan position
//  log2_width                   TU width log2
//  scanOrder                    scan position -> raster position table
//  coeff_rd_addr/coeff_rd_data  buffer read port, data valid one cycle later
//  coeff_wr_en/addr/data        buffer write port (data always zero)
//  sig_cg_flag, abs_sum         rebuilt significance flags and |level| sum
//  last_pos_x/y, last_valid     position of the last kept coefficient
//  last_err                     sticky: coefficient at best-1 was zero
module last_position_applier
   import rdoq_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   output logic                          done,
   input  logic [ADDR_WIDTH:0]           iBestLastIdxP1,
   input  logic [ADDR_WIDTH-1:0]         iLastScanPos,
   input  logic [2:0]                    log2_width,
   input  logic [ADDR_WIDTH-1:0]         scanOrder [MAX_COEFF_COUNT],
   output logic [ADDR_WIDTH-1:0]         coeff_rd_addr,
   input  logic signed [COEFF_WIDTH-1:0] coeff_rd_data,
   output logic                          coeff_wr_en,
   output logic [ADDR_WIDTH-1:0]         coeff_wr_addr,
   output logic signed [COEFF_WIDTH-1:0] coeff_wr_data,
   output logic [CG_COUNT-1:0]           sig_cg_flag,
   output logic [SUM_WIDTH-1:0]          abs_sum,
   output logic [4:0]                    last_pos_x,
   output logic [4:0]                    last_pos_y,
   output logic                          last_valid,
   output logic                          last_err
);

   // Magnitude in one extra bit so the most negative value does not overflow.
   function automatic logic [COEFF_WIDTH:0] coeff_abs(input coeff_t v);
      logic signed [COEFF_WIDTH:0] ext;
      ext = {v[COEFF_WIDTH-1], v};
      return ext[COEFF_WIDTH] ? $unsigned(-ext) : $unsigned(ext);
   endfunction

   applier_state_t        state;
   logic [ADDR_WIDTH-1:0] pos;
   logic [ADDR_WIDTH:0]   best;

   logic [ADDR_WIDTH:0]   last_p1;
   logic [ADDR_WIDTH:0]   best_clamped;
   logic [ADDR_WIDTH:0]   pos_ext;
   logic                  keep;
   logic                  nz;
   logic                  at_last;
   logic [COEFF_WIDTH:0]  mag;
   logic [4:0]            dec_x;
   logic [4:0]            dec_y;

   always_comb begin
      last_p1      = {1'b0, iLastScanPos} + (ADDR_WIDTH+1)'(1);
      best_clamped = (iBestLastIdxP1 > last_p1) ? last_p1 : iBestLastIdxP1;
      pos_ext      = {1'b0, pos};
      keep         = pos_ext < best;
      nz           = coeff_rd_data != '0;
      // at_last implies keep; best == 0 never matches.
      at_last      = (best != '0) && (pos_ext == best - (ADDR_WIDTH+1)'(1));
      mag          = coeff_abs(coeff_rd_data);
   end

   // Write strobe is combinational on EVAL so an asynchronous reset removes it at once.
   assign coeff_wr_en   = (state == ST_EVAL) && !keep && nz;
   assign coeff_wr_addr = coeff_rd_addr;
   assign coeff_wr_data = '0;

   // coeff_rd_addr doubles as the latched blk_pos of the coefficient under evaluation.
   last_pos_xy_decode u_xy (
      .blk_pos    (coeff_rd_addr),
      .log2_width (log2_width),
      .pos_x      (dec_x),
      .pos_y      (dec_y)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         pos           <= '0;
         best          <= '0;
         coeff_rd_addr <= '0;
         done          <= 1'b0;
         sig_cg_flag   <= '0;
         abs_sum       <= '0;
         last_pos_x    <= '0;
         last_pos_y    <= '0;
         last_valid    <= 1'b0;
         last_err      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) state <= ST_INIT;
            end
            ST_INIT: begin
               pos         <= iLastScanPos;
               best        <= best_clamped;
               sig_cg_flag <= '0;
               abs_sum     <= '0;
               last_pos_x  <= '0;
               last_pos_y  <= '0;
               last_valid  <= 1'b0;
               last_err    <= 1'b0;
               state       <= ST_RD;
            end
            ST_RD: begin
               coeff_rd_addr <= scanOrder[pos];
               state         <= ST_EVAL;
            end
            ST_EVAL: begin
               if (keep && nz) begin
                  sig_cg_flag[pos[ADDR_WIDTH-1:CG_SHIFT]] <= 1'b1;
                  abs_sum <= abs_sum + {{(SUM_WIDTH-COEFF_WIDTH-1){1'b0}}, mag};
               end
               if (at_last) begin
                  last_pos_x <= dec_x;
                  last_pos_y <= dec_y;
                  last_valid <= 1'b1;
                  if (!nz) last_err <= 1'b1;
               end
               if (pos == '0) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end else begin
                  pos   <= pos - 1'b1;
                  state <= ST_RD;
               end
            end
            ST_DONE: begin
               if (!start) begin
                  state <= ST_IDLE;
                  done  <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_last_position_applier.sv
module tb_last_position_applier;
   import rdoq_pkg::*;

   logic                          clk = 1'b0;
   logic                          rst;
   logic                          start;
   logic                          done;
   logic [ADDR_WIDTH:0]           iBestLastIdxP1;
   logic [ADDR_WIDTH-1:0]         iLastScanPos;
   logic [2:0]                    log2_width;
   logic [ADDR_WIDTH-1:0]         scan [MAX_COEFF_COUNT];
   logic [ADDR_WIDTH-1:0]         coeff_rd_addr;
   logic signed [COEFF_WIDTH-1:0] coeff_rd_data;
   logic                          coeff_wr_en;
   logic [ADDR_WIDTH-1:0]         coeff_wr_addr;
   logic signed [COEFF_WIDTH-1:0] coeff_wr_data;
   logic [CG_COUNT-1:0]           sig_cg_flag;
   logic [SUM_WIDTH-1:0]          abs_sum;
   logic [4:0]                    last_pos_x;
   logic [4:0]                    last_pos_y;
   logic                          last_valid;
   logic                          last_err;

   // Coefficient buffer: combinational read of the registered address.
   logic signed [COEFF_WIDTH-1:0] mem [MAX_COEFF_COUNT];
   assign coeff_rd_data = mem[coeff_rd_addr];

   always #5 clk = ~clk;

   last_position_applier dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .done           (done),
      .iBestLastIdxP1 (iBestLastIdxP1),
      .iLastScanPos   (iLastScanPos),
      .log2_width     (log2_width),
      .scanOrder      (scan),
      .coeff_rd_addr  (coeff_rd_addr),
      .coeff_rd_data  (coeff_rd_data),
      .coeff_wr_en    (coeff_wr_en),
      .coeff_wr_addr  (coeff_wr_addr),
      .coeff_wr_data  (coeff_wr_data),
      .sig_cg_flag    (sig_cg_flag),
      .abs_sum        (abs_sum),
      .last_pos_x     (last_pos_x),
      .last_pos_y     (last_pos_y),
      .last_valid     (last_valid),
      .last_err       (last_err)
   );

   int vec = 0;
   int bad = 0;

   // Reference results
   logic signed [COEFF_WIDTH-1:0] exp_mem [MAX_COEFF_COUNT];
   logic [CG_COUNT-1:0] exp_flags;
   longint              exp_sum;
   int                  exp_writes;
   int                  exp_x, exp_y;
   logic                exp_valid, exp_err;

   task automatic set_diag(input int lw);
      int w = 1 << lw;
      int p = 0;
      for (int i = 0; i < MAX_COEFF_COUNT; i++) scan[i] = 10'(i);
      for (int d = 0; d <= 2*w-2; d++)
         for (int y = (d < w ? d : w-1); y >= 0; y--)
            if (d - y < w) begin
               scan[p] = 10'(y*w + (d-y));
               p++;
            end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < MAX_COEFF_COUNT; i++) mem[i] = '0;
   endtask

   function automatic logic signed [COEFF_WIDTH-1:0] rnd_coeff();
      int r = $urandom_range(0, 9);
      if (r < 4) return '0;
      if (r == 4) return -16'sd32768;
      if (r == 5) return 16'sd32767;
      return 16'($urandom_range(0, 65535));
   endfunction

   // Scan-order model of the pass: positions below best keep their values and
   // contribute to flags/sum, positions best..n lose any nonzero value.
   task automatic model(input int lw, input int n, input int bp1);
      int w = 1 << lw;
      int best = (bp1 < n+1) ? bp1 : n+1;
      int b, v;
      exp_mem = mem;
      exp_flags = '0; exp_sum = 0; exp_writes = 0;
      exp_x = 0; exp_y = 0; exp_valid = 1'b0; exp_err = 1'b0;
      for (int p = 0; p <= n; p++) begin
         b = int'(scan[p]);
         v = int'(mem[b]);
         if (p >= best) begin
            if (v != 0) begin exp_writes++; exp_mem[b] = '0; end
         end else if (v != 0) begin
            exp_flags[p / CG_SIZE] = 1'b1;
            exp_sum += (v < 0) ? -v : v;
         end
      end
      if (best > 0) begin
         b = int'(scan[best-1]);
         exp_x = b % w; exp_y = b / w;
         exp_valid = 1'b1;
         exp_err = (mem[b] == 0);
      end
   endtask

   task automatic run_pass(input string name, input int lw, input int n, input int bp1, input int hold);
      int cyc = 0, wr = 0, diffs = 0;
      logic pend = 1'b0;
      logic [ADDR_WIDTH-1:0] pa = '0;
      logic signed [COEFF_WIDTH-1:0] pd = '0;
      model(lw, n, bp1);
      @(negedge clk);
      log2_width = 3'(lw); iLastScanPos = 10'(n); iBestLastIdxP1 = 11'(bp1);
      start = 1'b1;
      do begin
         @(posedge clk); #1;
         if (pend) begin mem[pa] = pd; pend = 1'b0; end
         @(negedge clk); cyc++;
         if (coeff_wr_en) begin pend = 1'b1; pa = coeff_wr_addr; pd = coeff_wr_data; wr++; end
      end while (!done && cyc < 5000);
      vec++; if (cyc !== 4 + 2*n) begin bad++; $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc, 4+2*n); end
      vec++; if (wr !== exp_writes) begin bad++; $display("FAIL %s writes: got %0d, expected %0d", name, wr, exp_writes); end
      vec++; if (sig_cg_flag !== exp_flags) begin bad++; $display("FAIL %s sig_cg_flag: got %h, expected %h", name, sig_cg_flag, exp_flags); end
      vec++; if (longint'(abs_sum) !== exp_sum) begin bad++; $display("FAIL %s abs_sum: got %0d, expected %0d", name, abs_sum, exp_sum); end
      vec++; if (last_valid !== exp_valid) begin bad++; $display("FAIL %s last_valid: got %0b, expected %0b", name, last_valid, exp_valid); end
      vec++; if (int'(last_pos_x) !== exp_x || int'(last_pos_y) !== exp_y) begin
         bad++; $display("FAIL %s last_xy: got (%0d,%0d), expected (%0d,%0d)", name, last_pos_x, last_pos_y, exp_x, exp_y);
      end
      vec++; if (last_err !== exp_err) begin bad++; $display("FAIL %s last_err: got %0b, expected %0b", name, last_err, exp_err); end
      for (int i = 0; i < MAX_COEFF_COUNT; i++) if (mem[i] !== exp_mem[i]) diffs++;
      vec++; if (diffs !== 0) begin bad++; $display("FAIL %s buffer: %0d entries differ, expected 0", name, diffs); end
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         vec++; if (done !== 1'b1) begin bad++; $display("FAIL %s done_hold: got %0b, expected 1", name, done); end
      end
      start = 1'b0;
      @(negedge clk);
      vec++; if (done !== 1'b0) begin bad++; $display("FAIL %s done_drop: got %0b, expected 0", name, done); end
      vec++; if (longint'(abs_sum) !== exp_sum) begin bad++; $display("FAIL %s sum_hold: got %0d, expected %0d", name, abs_sum, exp_sum); end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0;
      iBestLastIdxP1 = '0; iLastScanPos = '0; log2_width = 3'd2;
      repeat (3) @(negedge clk);
      vec++; if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %0b, expected 0", done); end
      vec++; if (coeff_wr_en !== 1'b0) begin bad++; $display("FAIL reset wr_en: got %0b, expected 0", coeff_wr_en); end
      vec++; if (sig_cg_flag !== '0) begin bad++; $display("FAIL reset flags: got %h, expected 0", sig_cg_flag); end
      vec++; if (abs_sum !== '0) begin bad++; $display("FAIL reset abs_sum: got %0d, expected 0", abs_sum); end
      vec++; if (last_pos_x !== '0 || last_pos_y !== '0) begin bad++; $display("FAIL reset last_xy: got (%0d,%0d), expected (0,0)", last_pos_x, last_pos_y); end
      vec++; if (last_valid !== 1'b0 || last_err !== 1'b0) begin bad++; $display("FAIL reset last_flags: got %0b%0b, expected 00", last_valid, last_err); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic_4x4();
      set_diag(2); clear_mem();
      for (int p = 0; p < 16; p++) mem[scan[p]] = 16'sd1;
      run_pass("basic4x4", 2, 15, 10, 0);
   endtask

   task automatic test_best_zero();
      set_diag(3); clear_mem();
      mem[scan[0]] = 16'sd5; mem[scan[1]] = -16'sd3; mem[scan[3]] = 16'sd2;
      run_pass("best_zero", 3, 3, 0, 0);
   endtask

   task automatic test_clamp();
      set_diag(3); clear_mem();
      for (int p = 0; p <= 32; p++) mem[scan[p]] = rnd_coeff();
      mem[scan[32]] = 16'sd9;
      run_pass("clamp", 3, 32, 40, 0);
   endtask

   task automatic test_cg5();
      int lastp = $urandom_range(0, 15);
      set_diag(5); clear_mem();
      for (int p = 0; p <= lastp; p++) mem[scan[p]] = rnd_coeff();
      mem[scan[lastp]] = -16'sd11;
      for (int p = 80; p < 96; p++) mem[scan[p]] = rnd_coeff();
      mem[scan[95]] = 16'sd4;
      run_pass("cg5", 5, 95, lastp + 1, 0);
   endtask

   task automatic test_neg_err();
      set_diag(2); clear_mem();
      mem[scan[0]] = -16'sd32768; mem[scan[1]] = 16'sd7; mem[scan[5]] = -16'sd4;
      run_pass("neg_err", 2, 6, 4, 3);
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         int lw = $urandom_range(2, 5);
         int w = 1 << lw;
         int n = $urandom_range(0, w*w - 1);
         int bp1 = $urandom_range(0, n + 3);
         set_diag(lw); clear_mem();
         for (int p = 0; p < w*w; p++) mem[scan[p]] = rnd_coeff();
         run_pass($sformatf("random%0d", it), lw, n, bp1, it % 2);
      end
   endtask

   task automatic test_reset_mid();
      set_diag(2); clear_mem();
      for (int p = 0; p < 16; p++) mem[scan[p]] = 16'sd1;
      @(negedge clk);
      log2_width = 3'd2; iLastScanPos = 10'd15; iBestLastIdxP1 = 11'd2; start = 1'b1;
      @(posedge clk);
      repeat (10) @(posedge clk);
      #1;
      vec++; if (coeff_wr_en !== 1'b1) begin bad++; $display("FAIL rst_mid wr_before: got %0b, expected 1", coeff_wr_en); end
      rst = 1'b1;
      #1;
      vec++; if (coeff_wr_en !== 1'b0) begin bad++; $display("FAIL rst_mid wr_after: got %0b, expected 0", coeff_wr_en); end
      vec++; if (done !== 1'b0 || abs_sum !== '0 || last_valid !== 1'b0) begin
         bad++; $display("FAIL rst_mid outputs: done %0b sum %0d valid %0b, expected all 0", done, abs_sum, last_valid);
      end
      @(negedge clk);
      start = 1'b0; rst = 1'b0;
      @(negedge clk);
      vec++; if (done !== 1'b0) begin bad++; $display("FAIL rst_mid idle: got done %0b, expected 0", done); end
      run_pass("after_rst", 2, 15, 2, 0);
   endtask

   initial begin
      for (int i = 0; i < MAX_COEFF_COUNT; i++) begin mem[i] = '0; scan[i] = 10'(i); end
      test_reset();
      test_basic_4x4();
      test_best_zero();
      test_clamp();
      test_cg5();
      test_neg_err();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
